// File: rtl/devinfo_pkg.sv
// Shared definitions for the UltraScale device-information register map.
package devinfo_pkg;

   // Register byte offsets within the device-info completer.
   typedef enum logic [7:0] {
      REG_STATUS   = 8'h00,
      REG_IDCODE   = 8'h04,
      REG_SERIAL_0 = 8'h08,
      REG_SERIAL_1 = 8'h0c,
      REG_SERIAL_2 = 8'h10,
      REG_USERCODE = 8'h14
   } regid_t;

   // STATUS register bit positions.
   localparam int unsigned IDCODE_VALID = 0;
   localparam int unsigned SERIAL_VALID = 1;

   // err_code values.
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_PSLVERR = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   // Next register in the read sequence; wraps to STATUS after USERCODE.
   function automatic regid_t next_reg(input regid_t r);
      unique case (r)
         REG_STATUS:   next_reg = REG_IDCODE;
         REG_IDCODE:   next_reg = REG_SERIAL_0;
         REG_SERIAL_0: next_reg = REG_SERIAL_1;
         REG_SERIAL_1: next_reg = REG_SERIAL_2;
         REG_SERIAL_2: next_reg = REG_USERCODE;
         default:      next_reg = REG_STATUS;
      endcase
   endfunction

endpackage

// File: rtl/apb_devinfo_reader_if.sv
// APB bus between the device-info reader (requester) and completer.
interface APB #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic pclk,
   input logic preset_n
);

   logic [31:0]           paddr;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport requester (
      input  pclk, preset_n, prdata, pready, pslverr,
      output paddr, psel, penable, pwrite, pwdata
   );

   modport completer (
      input  pclk, preset_n, paddr, psel, penable, pwrite, pwdata,
      output prdata, pready, pslverr
   );

endinterface

// File: rtl/apb_devinfo_reader.sv
// APB requester that polls device-info STATUS, then reads IDCODE,
// die serial and USERCODE into registered outputs.
module apb_devinfo_reader
   import devinfo_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = 32'h0,
   parameter bit          AUTO_START    = 1'b1,
   parameter int unsigned POLL_INTERVAL = 1024,
   parameter int unsigned MAX_POLLS     = 4096
) (
   input  logic         pclk,
   input  logic         preset_n,
   APB.requester        apb,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [1:0]   err_code,
   output logic [31:0]  idcode,
   output logic [95:0]  die_serial,
   output logic [31:0]  usercode
);

   localparam int unsigned PW = $clog2(MAX_POLLS + 1);
   localparam int unsigned WW = $clog2(POLL_INTERVAL + 1);

   if ($bits(apb.prdata) != 32) begin : g_width_check
      $error("apb_devinfo_reader requires an APB DATA_WIDTH of 32");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_DONE, S_ERROR
   } state_t;

   state_t        state_q, state_d;
   regid_t        idx_q, idx_d;
   logic [PW-1:0] polls_q, polls_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          auto_q;
   logic          launch;
   logic          psel_q, psel_d, penable_q, penable_d;
   logic [31:0]   paddr_q, paddr_d;
   logic          busy_d, done_d, err_d;
   logic [1:0]    code_d;
   logic [31:0]   id_d, uc_d;
   logic [95:0]   ser_d;

   assign apb.psel    = psel_q;
   assign apb.penable = penable_q;
   assign apb.paddr   = paddr_q;
   assign apb.pwrite  = 1'b0;
   assign apb.pwdata  = '0;

   // State and output registers; reset drops psel asynchronously.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q    <= S_IDLE;
         idx_q      <= REG_STATUS;
         polls_q    <= '0;
         wait_q     <= '0;
         auto_q     <= AUTO_START;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         paddr_q    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
         idcode     <= '0;
         die_serial <= '0;
         usercode   <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         polls_q    <= polls_d;
         wait_q     <= wait_d;
         auto_q     <= 1'b0;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         paddr_q    <= paddr_d;
         busy       <= busy_d;
         done       <= done_d;
         err        <= err_d;
         err_code   <= code_d;
         idcode     <= id_d;
         die_serial <= ser_d;
         usercode   <= uc_d;
      end
   end

   // Next-state, bus control and captured-field logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      polls_d = polls_q;
      wait_d  = wait_q;
      busy_d  = busy;
      done_d  = done;
      err_d   = err;
      code_d  = err_code;
      id_d    = idcode;
      ser_d   = die_serial;
      uc_d    = usercode;
      paddr_d = paddr_q;
      launch  = 1'b0;

      unique case (state_q)
         S_IDLE:          launch = start || auto_q;
         S_DONE, S_ERROR: launch = start;
         S_SETUP:         state_d = S_ACCESS;
         S_ACCESS: begin
            if (apb.pready) begin
               if (apb.pslverr) begin
                  code_d  = ERR_PSLVERR;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
                  state_d = S_ERROR;
               end else if (idx_q == REG_STATUS) begin
                  polls_d = polls_q + 1'b1;
                  if (apb.prdata[IDCODE_VALID] && apb.prdata[SERIAL_VALID]) begin
                     idx_d   = REG_IDCODE;
                     state_d = S_SETUP;
                  end else if (polls_d >= PW'(MAX_POLLS)) begin
                     code_d  = ERR_TIMEOUT;
                     busy_d  = 1'b0;
                     err_d   = 1'b1;
                     state_d = S_ERROR;
                  end else begin
                     wait_d  = '0;
                     state_d = S_WAIT;
                  end
               end else begin
                  unique case (idx_q)
                     REG_IDCODE:   id_d          = apb.prdata;
                     REG_SERIAL_0: ser_d[95:64]  = apb.prdata;
                     REG_SERIAL_1: ser_d[63:32]  = apb.prdata;
                     REG_SERIAL_2: ser_d[31:0]   = apb.prdata;
                     default:      uc_d          = apb.prdata;
                  endcase
                  if (idx_q == REG_USERCODE) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     idx_d   = next_reg(idx_q);
                     state_d = S_SETUP;
                  end
               end
            end
         end
         S_WAIT: begin
            if (wait_q == WW'(POLL_INTERVAL - 1)) begin
               idx_d   = REG_STATUS;
               state_d = S_SETUP;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         done_d  = 1'b0;
         err_d   = 1'b0;
         code_d  = ERR_NONE;
         polls_d = '0;
         busy_d  = 1'b1;
         idx_d   = REG_STATUS;
         state_d = S_SETUP;
      end

      // Address is loaded on entry to SETUP and held through ACCESS.
      if (state_d == S_SETUP) paddr_d = BASE_ADDR + 32'(idx_d);
      psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
      penable_d = (state_d == S_ACCESS);
   end

endmodule

// File: tb/tb_apb_devinfo_reader.sv
// Self-checking bench for apb_devinfo_reader with behavioural completers.
module tb_apb_devinfo_reader;
   import devinfo_pkg::*;

   localparam logic [31:0] BASE_A = 32'h100;
   localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

   logic pclk = 1'b0;
   logic preset_n = 1'b0;
   always #5 pclk = ~pclk;

   APB #(.DATA_WIDTH(32)) bus_a (.pclk(pclk), .preset_n(preset_n));
   APB #(.DATA_WIDTH(32)) bus_b (.pclk(pclk), .preset_n(preset_n));

   logic        start_a = 1'b0, start_b = 1'b0;
   logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [1:0]  code_a, code_b;
   logic [31:0] id_a, uc_a, id_b, uc_b;
   logic [95:0] ser_a, ser_b;

   apb_devinfo_reader #(.BASE_ADDR(BASE_A), .AUTO_START(1'b1),
                        .POLL_INTERVAL(4), .MAX_POLLS(16)) dut_a (
      .pclk(pclk), .preset_n(preset_n), .apb(bus_a), .start(start_a),
      .busy(busy_a), .done(done_a), .err(err_a), .err_code(code_a),
      .idcode(id_a), .die_serial(ser_a), .usercode(uc_a));

   apb_devinfo_reader #(.BASE_ADDR(32'h0), .AUTO_START(1'b0),
                        .POLL_INTERVAL(2), .MAX_POLLS(3)) dut_b (
      .pclk(pclk), .preset_n(preset_n), .apb(bus_b), .start(start_b),
      .busy(busy_b), .done(done_b), .err(err_b), .err_code(code_b),
      .idcode(id_b), .die_serial(ser_b), .usercode(uc_b));

   // Completer A model state.
   int unsigned ws_cfg = 0, ws_cnt = 0, stat_fail_n = 0, stat_reads = 0;
   logic [31:0] m_id, m_s0, m_s1, m_s2, m_uc, err_addr;
   logic [31:0] off_a;
   assign off_a = bus_a.paddr - BASE_A;

   // Completer A read data, selected by register offset.
   always_comb begin
      case (off_a)
         32'h00:  bus_a.prdata = (stat_reads < stat_fail_n) ? 32'h1 : 32'h3;
         32'h04:  bus_a.prdata = m_id;
         32'h08:  bus_a.prdata = m_s0;
         32'h0c:  bus_a.prdata = m_s1;
         32'h10:  bus_a.prdata = m_s2;
         32'h14:  bus_a.prdata = m_uc;
         default: bus_a.prdata = 32'hDEAD_BEEF;
      endcase
   end
   assign bus_a.pready  = (ws_cnt >= ws_cfg);
   assign bus_a.pslverr = (bus_a.paddr == err_addr);

   // Completer B: always ready, STATUS stuck at 2'b10.
   assign bus_b.pready  = 1'b1;
   assign bus_b.prdata  = 32'h2;
   assign bus_b.pslverr = 1'b0;

   typedef struct { logic [31:0] addr; int cyc; } xfer_t;
   xfer_t       obs_q[$];
   logic [31:0] exp_q[$];
   int          cyc = 0, viol = 0, b_stat = 0, b_data = 0;
   int          n_pass = 0, n_total = 0;
   logic        p_setup = 1'b0, p_pend = 1'b0;
   logic [31:0] p_addr = '0;

   // Bus A monitor: records completed transfers, checks protocol stability.
   always @(posedge pclk) begin
      if (!preset_n) begin
         p_setup = 1'b0;
         p_pend  = 1'b0;
      end else begin
         if (bus_a.penable && !bus_a.psel) viol++;
         if ((p_setup || p_pend) &&
             !(bus_a.psel && bus_a.penable && bus_a.paddr == p_addr)) viol++;
         p_setup = bus_a.psel && !bus_a.penable;
         p_pend  = bus_a.psel && bus_a.penable && !bus_a.pready;
         p_addr  = bus_a.paddr;
         if (bus_a.psel && bus_a.penable && bus_a.pready) begin
            obs_q.push_back('{bus_a.paddr, cyc});
            if (bus_a.paddr == BASE_A) stat_reads <= stat_reads + 1;
         end
      end
      if (bus_a.psel && bus_a.penable && !bus_a.pready) ws_cnt <= ws_cnt + 1;
      else ws_cnt <= 0;
      if (bus_b.psel && bus_b.penable) begin
         if (bus_b.paddr == 32'h0) b_stat++;
         else b_data++;
      end
      cyc++;
   end

   task automatic set_data(input logic [31:0] id, input logic [95:0] s, input logic [31:0] uc);
      m_id = id; m_s0 = s[95:64]; m_s1 = s[63:32]; m_s2 = s[31:0]; m_uc = uc;
   endtask

   task automatic push_seq(input int n_status, input int last_off);
      for (int i = 0; i < n_status; i++) exp_q.push_back(BASE_A);
      for (int o = 4; o <= last_off; o += 4) exp_q.push_back(BASE_A + 32'(o));
   endtask

   // Runs bus A until busy falls; optional start pulse and mid-run restart pulse.
   task automatic run_a(input bit pulse, input int restart_at, output int setup_c, output int end_c);
      bit seen_busy = 1'b0;
      setup_c = -1;
      end_c   = -1;
      if (pulse) begin
         @(negedge pclk);
         start_a = 1'b1;
      end
      for (int k = 0; k < 600; k++) begin
         @(negedge pclk);
         start_a = (k == restart_at);
         if (setup_c < 0 && bus_a.psel) setup_c = cyc;
         if (busy_a) seen_busy = 1'b1;
         if (seen_busy && !busy_a) begin
            end_c = cyc;
            break;
         end
      end
      start_a = 1'b0;
      if (end_c < 0) begin
         n_total++;
         $display("FAIL run_a_timeout: busy got %0b want 0 within 600 cycles", busy_a);
      end
   endtask

   // Pops the scoreboard against observed transfers; returns completion cycles.
   task automatic drain(input string tag, output int cycs[$]);
      xfer_t o;
      cycs.delete();
      while (exp_q.size() > 0) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         n_total++;
         if (obs_q.size() == 0) begin
            $display("FAIL %s_addr: got none want %h", tag, e);
         end else begin
            o = obs_q.pop_front();
            cycs.push_back(o.cyc);
            if (o.addr !== e) $display("FAIL %s_addr: got %h want %h", tag, o.addr, e);
            else n_pass++;
         end
      end
      n_total++;
      if (obs_q.size() != 0) $display("FAIL %s_extra: got %0d extra transfers want 0", tag, obs_q.size());
      else n_pass++;
   endtask

   task automatic test_reset;
      stat_fail_n = 0; ws_cfg = 0; err_addr = NO_ERR;
      set_data(32'h04A6_2093, 96'h0123_4567_89AB_CDEF_0011_2233, 32'hCAFE_F00D);
      repeat (3) @(negedge pclk);
      n_total++; if (bus_a.psel !== 1'b0)    $display("FAIL reset_psel: got %b want 0", bus_a.psel); else n_pass++;
      n_total++; if (bus_a.penable !== 1'b0) $display("FAIL reset_penable: got %b want 0", bus_a.penable); else n_pass++;
      n_total++; if (bus_a.pwrite !== 1'b0)  $display("FAIL reset_pwrite: got %b want 0", bus_a.pwrite); else n_pass++;
      n_total++; if (bus_a.paddr !== 32'h0)  $display("FAIL reset_paddr: got %h want 0", bus_a.paddr); else n_pass++;
      n_total++; if ({busy_a, done_a, err_a} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy_a, done_a, err_a}); else n_pass++;
      n_total++; if (code_a !== 2'd0)        $display("FAIL reset_code: got %0d want 0", code_a); else n_pass++;
      n_total++; if ({id_a, ser_a, uc_a} !== 160'h0) $display("FAIL reset_fields: got %h want 0", {id_a, ser_a, uc_a}); else n_pass++;
      obs_q.delete();
      preset_n = 1'b1;
   endtask

   task automatic test_auto_start;
      int sc, ec;
      int cy[$];
      push_seq(1, 'h14);
      run_a(1'b0, -1, sc, ec);
      drain("auto", cy);
      n_total++; if (ec - sc != 12) $display("FAIL auto_latency: got %0d want 12", ec - sc); else n_pass++;
      n_total++; if ({done_a, err_a} !== 2'b10) $display("FAIL auto_done_err: got %b want 10", {done_a, err_a}); else n_pass++;
      n_total++; if (code_a !== ERR_NONE) $display("FAIL auto_code: got %0d want 0", code_a); else n_pass++;
      n_total++; if (id_a !== 32'h04A6_2093) $display("FAIL auto_idcode: got %h want 04a62093", id_a); else n_pass++;
      n_total++; if (ser_a !== 96'h0123_4567_89AB_CDEF_0011_2233) $display("FAIL auto_serial: got %h want 0123456789abcdef00112233", ser_a); else n_pass++;
      n_total++; if (uc_a !== 32'hCAFE_F00D) $display("FAIL auto_usercode: got %h want cafef00d", uc_a); else n_pass++;
      n_total++; if (viol != 0) $display("FAIL auto_protocol: got %0d violations want 0", viol); else n_pass++;
   endtask

   task automatic test_poll;
      int sc, ec;
      int cy[$];
      @(negedge pclk);
      stat_fail_n = 3; stat_reads = 0; obs_q.delete();
      push_seq(4, 'h14);
      run_a(1'b1, -1, sc, ec);
      drain("poll", cy);
      for (int i = 1; i < 4 && i < cy.size(); i++) begin
         n_total++;
         if (cy[i] - cy[i-1] != 6) $display("FAIL poll_gap%0d: got %0d want 6", i, cy[i] - cy[i-1]);
         else n_pass++;
      end
      n_total++; if (ec - sc != 30) $display("FAIL poll_latency: got %0d want 30", ec - sc); else n_pass++;
      n_total++; if ({done_a, err_a} !== 2'b10) $display("FAIL poll_done_err: got %b want 10", {done_a, err_a}); else n_pass++;
      stat_fail_n = 0;
   endtask

   task automatic test_timeout;
      @(negedge pclk);
      b_stat = 0; b_data = 0;
      start_b = 1'b1;
      @(negedge pclk);
      start_b = 1'b0;
      for (int k = 0; k < 100 && busy_b; k++) @(negedge pclk);
      n_total++; if (busy_b !== 1'b0) $display("FAIL timeout_busy: got %b want 0", busy_b); else n_pass++;
      n_total++; if (b_stat != 3) $display("FAIL timeout_polls: got %0d want 3", b_stat); else n_pass++;
      n_total++; if (b_data != 0) $display("FAIL timeout_data_reads: got %0d want 0", b_data); else n_pass++;
      n_total++; if ({done_b, err_b} !== 2'b01) $display("FAIL timeout_done_err: got %b want 01", {done_b, err_b}); else n_pass++;
      n_total++; if (code_b !== ERR_TIMEOUT) $display("FAIL timeout_code: got %0d want 2", code_b); else n_pass++;
   endtask

   task automatic test_pslverr;
      int sc, ec;
      int cy[$];
      @(negedge pclk);
      obs_q.delete();
      set_data(32'h1111_1111, 96'h2222_2222_3333_3333_4444_4444, 32'h5555_5555);
      err_addr = BASE_A + 32'h0c;
      push_seq(1, 'h0c);
      run_a(1'b1, -1, sc, ec);
      drain("slverr", cy);
      n_total++; if ({done_a, err_a} !== 2'b01) $display("FAIL slverr_done_err: got %b want 01", {done_a, err_a}); else n_pass++;
      n_total++; if (code_a !== ERR_PSLVERR) $display("FAIL slverr_code: got %0d want 1", code_a); else n_pass++;
      n_total++; if (id_a !== 32'h1111_1111) $display("FAIL slverr_idcode: got %h want 11111111", id_a); else n_pass++;
      n_total++; if (ser_a !== 96'h2222_2222_89AB_CDEF_0011_2233) $display("FAIL slverr_serial: got %h want 2222222289abcdef00112233", ser_a); else n_pass++;
      n_total++; if (uc_a !== 32'hCAFE_F00D) $display("FAIL slverr_usercode: got %h want cafef00d", uc_a); else n_pass++;
      err_addr = NO_ERR;
   endtask

   task automatic test_wait_states;
      int sc, ec, v0;
      int cy[$];
      @(negedge pclk);
      obs_q.delete();
      set_data(32'h04A6_2093, 96'h0123_4567_89AB_CDEF_0011_2233, 32'hCAFE_F00D);
      ws_cfg = 3; v0 = viol;
      push_seq(1, 'h14);
      run_a(1'b1, 6, sc, ec);
      drain("ws", cy);
      n_total++; if (ec - sc != 30) $display("FAIL ws_latency: got %0d want 30", ec - sc); else n_pass++;
      n_total++; if (viol != v0) $display("FAIL ws_protocol: got %0d violations want 0", viol - v0); else n_pass++;
      n_total++; if (ser_a !== 96'h0123_4567_89AB_CDEF_0011_2233) $display("FAIL ws_serial: got %h want 0123456789abcdef00112233", ser_a); else n_pass++;
      n_total++; if ({done_a, err_a} !== 2'b10) $display("FAIL ws_done_err: got %b want 10", {done_a, err_a}); else n_pass++;
      ws_cfg = 0;
   endtask

   task automatic test_reset_mid;
      int sc, ec, rel_c;
      bit hit = 1'b0;
      int cy[$];
      @(negedge pclk);
      start_a = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge pclk);
         start_a = 1'b0;
         if (bus_a.psel && bus_a.penable && bus_a.paddr == BASE_A + 32'h4) begin
            hit = 1'b1;
            break;
         end
      end
      n_total++; if (!hit) $display("FAIL rstmid_reach: got no IDCODE access want one"); else n_pass++;
      preset_n = 1'b0;
      #1;
      n_total++; if ({bus_a.psel, bus_a.penable} !== 2'b00) $display("FAIL rstmid_psel: got %b want 00", {bus_a.psel, bus_a.penable}); else n_pass++;
      @(negedge pclk);
      n_total++; if ({busy_a, done_a, err_a, code_a} !== 5'b0) $display("FAIL rstmid_flags: got %b want 00000", {busy_a, done_a, err_a, code_a}); else n_pass++;
      n_total++; if ({id_a, ser_a, uc_a, bus_a.paddr} !== 192'h0) $display("FAIL rstmid_fields: got %h want 0", {id_a, ser_a, uc_a, bus_a.paddr}); else n_pass++;
      @(negedge pclk);
      obs_q.delete();
      preset_n = 1'b1;
      rel_c = cyc;
      push_seq(1, 'h14);
      run_a(1'b0, -1, sc, ec);
      drain("rstmid", cy);
      n_total++; if (sc != rel_c + 1) $display("FAIL rstmid_autostart: got cycle %0d want %0d", sc, rel_c + 1); else n_pass++;
      n_total++; if ({done_a, id_a} !== {1'b1, 32'h04A6_2093}) $display("FAIL rstmid_result: got %h want 104a62093", {done_a, id_a}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_auto_start();
      test_poll();
      test_timeout();
      test_pslverr();
      test_wait_states();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
